// File: rtl/frame_config_sequencer_pkg.sv
// Shared types and constants for the frame configuration sequencer.
// The CHK state exists only when CONFIG_CHECKSUM_EN is defined.
package frame_config_sequencer_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_ADDR   = 3'd1,
        ST_DATA   = 3'd2,
`ifdef CONFIG_CHECKSUM_EN
        ST_CHK    = 3'd3,
`endif
        ST_STROBE = 3'd4
    } state_e;

    localparam logic [31:0] SYNC_WORD   = 32'hFAB0_FAB1;
    localparam logic [31:0] DESYNC_WORD = 32'hFAB0_FAB0;

    // Address word layout: column in the top byte, frame in the next byte.
    localparam int ADDR_FIELD_W = 8;
    localparam int COL_MSB      = 31;
    localparam int COL_LSB      = 24;
    localparam int FRAME_MSB    = 23;
    localparam int FRAME_LSB    = 16;

    function automatic logic field_in_range(input logic [ADDR_FIELD_W-1:0] field, input int limit);
        return (int'(field) < limit);
    endfunction

endpackage

// File: rtl/frame_strobe_decoder.sv
// Decodes a latched (column, frame) address into a one-hot frame strobe vector.
module frame_strobe_decoder
    import frame_config_sequencer_pkg::*;
#(
    parameter int NumColumns      = 4,
    parameter int MaxFramesPerCol = 20
) (
    input  logic [ADDR_FIELD_W-1:0]               col_i,
    input  logic [ADDR_FIELD_W-1:0]               frame_i,
    input  logic                                  en_i,
    output logic [NumColumns*MaxFramesPerCol-1:0] strobe_o
);

    for (genvar c = 0; c < NumColumns; c++) begin : g_col
        for (genvar f = 0; f < MaxFramesPerCol; f++) begin : g_frame
            assign strobe_o[c*MaxFramesPerCol+f] = en_i
                && (col_i == ADDR_FIELD_W'(c))
                && (frame_i == ADDR_FIELD_W'(f));
        end
    end

endmodule

// File: rtl/frame_config_sequencer.sv
// Streams sync / address / data / desync words into a frame register and pulses
// the addressed frame strobe. Optional checksum word enabled by CONFIG_CHECKSUM_EN.
module frame_config_sequencer
    import frame_config_sequencer_pkg::*;
#(
    parameter int FrameBitsPerRow = 32,
    parameter int NumRows         = 4,
    parameter int MaxFramesPerCol = 20,
    parameter int NumColumns      = 4,
    parameter int StrobeCycles    = 2
) (
    input  logic                                  CLK,
    input  logic                                  reset,
    input  logic [FrameBitsPerRow-1:0]            s_data,
    input  logic                                  s_valid,
    output logic                                  s_ready,
    output logic [NumRows*FrameBitsPerRow-1:0]    FrameData,
    output logic [NumColumns*MaxFramesPerCol-1:0] FrameStrobe,
    output logic                                  busy,
    output logic                                  done,
    output logic                                  error
);

    localparam int ROW_W = (NumRows > 1) ? $clog2(NumRows) : 1;

    state_e                             state_q;
    logic [ROW_W-1:0]                   row_q;
    logic [3:0]                         strb_cnt_q;
    logic [ADDR_FIELD_W-1:0]            col_q;
    logic [ADDR_FIELD_W-1:0]            frame_q;
    logic [NumRows*FrameBitsPerRow-1:0] frame_data_q;
    logic                               done_q;
    logic                               error_q;
`ifdef CONFIG_CHECKSUM_EN
    logic [FrameBitsPerRow-1:0]         csum_q;
`endif

    logic                    accept_s;
    logic                    strobe_en_s;
    logic [ADDR_FIELD_W-1:0] word_col_s;
    logic [ADDR_FIELD_W-1:0] word_frame_s;

    assign accept_s     = s_valid & s_ready;
    assign strobe_en_s  = (state_q == ST_STROBE);
    assign word_col_s   = s_data[COL_MSB:COL_LSB];
    assign word_frame_s = s_data[FRAME_MSB:FRAME_LSB];

    assign s_ready   = (state_q != ST_STROBE);
    assign busy      = (state_q != ST_IDLE);
    assign done      = done_q;
    assign error     = error_q;
    assign FrameData = frame_data_q;

    // Sequencer FSM together with frame register, counters and status flags.
    always_ff @(posedge CLK) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            row_q        <= '0;
            strb_cnt_q   <= 4'd0;
            col_q        <= '0;
            frame_q      <= '0;
            frame_data_q <= '0;
            done_q       <= 1'b0;
            error_q      <= 1'b0;
`ifdef CONFIG_CHECKSUM_EN
            csum_q       <= '0;
`endif
        end else begin
            done_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (accept_s && (s_data[31:0] == SYNC_WORD)) begin
                        state_q <= ST_ADDR;
                    end
                end
                ST_ADDR: begin
                    if (accept_s) begin
                        if (s_data[31:0] == DESYNC_WORD) begin
                            state_q <= ST_IDLE;
                            done_q  <= 1'b1;
                        end else if (!field_in_range(word_col_s, NumColumns)
                                     || !field_in_range(word_frame_s, MaxFramesPerCol)) begin
                            error_q <= 1'b1;
                            state_q <= ST_IDLE;
                        end else begin
                            col_q   <= word_col_s;
                            frame_q <= word_frame_s;
                            row_q   <= '0;
`ifdef CONFIG_CHECKSUM_EN
                            csum_q  <= '0;
`endif
                            state_q <= ST_DATA;
                        end
                    end
                end
                ST_DATA: begin
                    if (accept_s) begin
                        for (int r = 0; r < NumRows; r++) begin
                            if (row_q == ROW_W'(r)) begin
                                frame_data_q[r*FrameBitsPerRow +: FrameBitsPerRow] <= s_data;
                            end
                        end
`ifdef CONFIG_CHECKSUM_EN
                        csum_q <= csum_q ^ s_data;
`endif
                        row_q <= row_q + ROW_W'(1);
                        if (row_q == ROW_W'(NumRows - 1)) begin
                            strb_cnt_q <= 4'd0;
`ifdef CONFIG_CHECKSUM_EN
                            state_q    <= ST_CHK;
`else
                            state_q    <= ST_STROBE;
`endif
                        end
                    end
                end
`ifdef CONFIG_CHECKSUM_EN
                ST_CHK: begin
                    if (accept_s) begin
                        if (s_data == csum_q) begin
                            state_q <= ST_STROBE;
                        end else begin
                            error_q <= 1'b1;
                            state_q <= ST_ADDR;
                        end
                    end
                end
`endif
                ST_STROBE: begin
                    if (strb_cnt_q == 4'(StrobeCycles - 1)) begin
                        state_q <= ST_ADDR;
                    end else begin
                        strb_cnt_q <= strb_cnt_q + 4'd1;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    frame_strobe_decoder #(
        .NumColumns      (NumColumns),
        .MaxFramesPerCol (MaxFramesPerCol)
    ) u_strobe_decoder (
        .col_i    (col_q),
        .frame_i  (frame_q),
        .en_i     (strobe_en_s),
        .strobe_o (FrameStrobe)
    );

endmodule
